// File: rtl/shiftreg_in_buf_pkg.sv
// Shared constants and width helpers for the serial-in word buffer.
// Bit-order encodings plus $clog2-based port/pointer widths.
package shiftreg_in_buf_pkg;

  localparam int ORDER_MSB = 1;
  localparam int ORDER_LSB = 0;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int lvl_w(input int d);
    return $clog2(d + 1);
  endfunction

  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/shiftreg_in_buf_if.sv
// Output word stream of the serial-in buffer.
// Master presents words; slave accepts them with out_ready.
interface shiftreg_in_buf_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/shiftreg_in_fifo.sv
// Small word FIFO behind the shift register.
// A push into a full FIFO succeeds only when a pop frees a slot on the same edge.
module shiftreg_in_fifo
  import shiftreg_in_buf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [lvl_w(DEPTH)-1:0]  level
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             wr, rd;

  assign full  = (cnt_q == LW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  // Gate the head so an empty buffer always shows zero
  assign rdata = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    rd     = pop & ~empty;
    wr     = push & (~full | rd);
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + PW'(1);
    end
    if (rd) rptr_d = rptr_q + PW'(1);
    cnt_d = cnt_q + LW'(wr) - LW'(rd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/shiftreg_in_buf.sv
// Serial-to-parallel receiver with framing, bit count and buffered output.
// Completed words go to a FIFO; words that find it full are dropped and flagged.
module shiftreg_in_buf
  import shiftreg_in_buf_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = ORDER_MSB
) (
  input  logic                     serclk,
  input  logic                     reset_n,
  input  logic                     ser_in,
  input  logic                     enable,
  input  logic                     frame_start,
  input  logic                     clear_overrun,
  output logic [lvl_w(DEPTH)-1:0]  level,
  output logic [cnt_w(WIDTH)-1:0]  bit_cnt,
  output logic                     overrun,
  shiftreg_in_buf_if.master        bus
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d, sr_base;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
  logic             ov_q, ov_d;
  logic             push, pop, full, empty;

  always_comb begin
    sr_base  = frame_start ? '0 : sr_q;
    cnt_base = frame_start ? '0 : cnt_q;
    sr_d     = sr_base;
    cnt_d    = cnt_base;
    push     = 1'b0;
    if (enable) begin
      if (MSB_FIRST == ORDER_MSB) sr_d = {sr_base[WIDTH-2:0], ser_in};
      else                        sr_d = {ser_in, sr_base[WIDTH-1:1]};
      if (cnt_base == CW'(WIDTH - 1)) begin
        cnt_d = '0;
        push  = 1'b1;
      end else begin
        cnt_d = cnt_base + CW'(1);
      end
    end
  end

  assign pop = bus.out_valid & bus.out_ready;

  // Set beats clear when a drop coincides with clear_overrun
  always_comb begin
    ov_d = ov_q;
    if (clear_overrun)       ov_d = 1'b0;
    if (push & full & ~pop)  ov_d = 1'b1;
  end

  always_ff @(posedge serclk) begin
    if (!reset_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
    end
  end

  shiftreg_in_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (serclk),
    .rst_n (reset_n),
    .push  (push),
    .wdata (sr_d),
    .pop   (pop),
    .rdata (bus.out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.out_valid = ~empty;
  assign bit_cnt       = cnt_q;
  assign overrun       = ov_q;

endmodule

// File: tb/tb_shiftreg_in_buf.sv
// Bench for shiftreg_in_buf: MSB-first and LSB-first instances on shared stimulus,
// directed tables and sequences plus random traffic against a queue-based model.
module tb_shiftreg_in_buf;
  import shiftreg_in_buf_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = lvl_w(D);
  localparam int CW = cnt_w(W);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic ser = 1'b0, en = 1'b0, fs = 1'b0, clr = 1'b0, rdy = 1'b0;
  logic [LW-1:0] lvl1, lvl0;
  logic [CW-1:0] cnt1, cnt0;
  logic          ov1, ov0;

  shiftreg_in_buf_if #(.WIDTH(W)) if1 ();
  shiftreg_in_buf_if #(.WIDTH(W)) if0 ();
  assign if1.out_ready = rdy;
  assign if0.out_ready = rdy;

  shiftreg_in_buf #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut1 (
    .serclk        (clk),
    .reset_n       (rst_n),
    .ser_in        (ser),
    .enable        (en),
    .frame_start   (fs),
    .clear_overrun (clr),
    .level         (lvl1),
    .bit_cnt       (cnt1),
    .overrun       (ov1),
    .bus           (if1)
  );

  shiftreg_in_buf #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) dut0 (
    .serclk        (clk),
    .reset_n       (rst_n),
    .ser_in        (ser),
    .enable        (en),
    .frame_start   (fs),
    .clear_overrun (clr),
    .level         (lvl0),
    .bit_cnt       (cnt0),
    .overrun       (ov0),
    .bus           (if0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit           m_bits[$];
  logic [W-1:0] m_q1[$];
  logic [W-1:0] m_q0[$];
  bit           m_ov = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] assemble(bit msb);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) w[W-1-i] = m_bits[i];
      else     w[i]     = m_bits[i];
    end
    return w;
  endfunction

  task automatic model(bit e, bit b, bit f, bit r, bit c, bit rs);
    bit pop, drop;
    if (rs) begin
      m_bits.delete();
      m_q1.delete();
      m_q0.delete();
      m_ov = 1'b0;
      return;
    end
    pop  = r && (m_q1.size() > 0);
    drop = 1'b0;
    if (f) m_bits.delete();
    if (pop) begin
      void'(m_q1.pop_front());
      void'(m_q0.pop_front());
    end
    if (e) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        if (m_q1.size() < D) begin
          m_q1.push_back(assemble(1'b1));
          m_q0.push_back(assemble(1'b0));
        end else begin
          drop = 1'b1;
        end
        m_bits.delete();
      end
    end
    if (drop)   m_ov = 1'b1;
    else if (c) m_ov = 1'b0;
  endtask

  task automatic check_model();
    logic [W-1:0] h1, h0;
    h1 = '0;
    h0 = '0;
    if (m_q1.size() > 0) begin
      h1 = m_q1[0];
      h0 = m_q0[0];
    end
    chk("valid_msb", 32'(if1.out_valid), 32'(m_q1.size() > 0));
    chk("data_msb",  32'(if1.out_data),  32'(h1));
    chk("level_msb", 32'(lvl1),          32'(m_q1.size()));
    chk("cnt_msb",   32'(cnt1),          32'(m_bits.size()));
    chk("ovr_msb",   32'(ov1),           32'(m_ov));
    chk("valid_lsb", 32'(if0.out_valid), 32'(m_q0.size() > 0));
    chk("data_lsb",  32'(if0.out_data),  32'(h0));
    chk("level_lsb", 32'(lvl0),          32'(m_q0.size()));
    chk("cnt_lsb",   32'(cnt0),          32'(m_bits.size()));
    chk("ovr_lsb",   32'(ov0),           32'(m_ov));
  endtask

  task automatic step(bit e, bit b, bit f, bit r, bit c, bit rs);
    @(negedge clk);
    en    = e;
    ser   = b;
    fs    = f;
    rdy   = r;
    clr   = c;
    rst_n = ~rs;
    @(posedge clk);
    model(e, b, f, r, c, rs);
    #1;
    check_model();
  endtask

  task automatic send(logic [W-1:0] w, bit r, bit r_last);
    for (int i = 0; i < W; i++)
      step(1'b1, w[W-1-i], 1'b0, (i == W-1) ? r_last : r, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 2*D && m_q1.size() > 0; k++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", 32'(if1.out_valid), 32'd0);
  endtask

  typedef struct {
    bit         e;
    bit         b;
    bit         rs;
    bit         ev;
    logic [7:0] ed;
    int         el;
    int         ec;
  } vec_t;

  vec_t         tv[10];
  bit           pat[8];
  logic [W-1:0] words[5];

  initial begin
    pat = '{1, 0, 1, 0, 0, 1, 0, 1};
    tv[0] = '{e: 0, b: 0, rs: 1, ev: 0, ed: 8'h00, el: 0, ec: 0};
    for (int i = 1; i <= 8; i++)
      tv[i] = '{e: 1, b: pat[i-1], rs: 0, ev: (i == 8),
                ed: (i == 8) ? 8'hA5 : 8'h00,
                el: (i == 8) ? 1 : 0, ec: i % 8};
    tv[9] = '{e: 0, b: 0, rs: 0, ev: 1, ed: 8'hA5, el: 1, ec: 0};

    for (int i = 0; i < 10; i++) begin
      step(tv[i].e, tv[i].b, 1'b0, 1'b0, 1'b0, tv[i].rs);
      chk("tv_valid", 32'(if1.out_valid), 32'(tv[i].ev));
      chk("tv_data1", 32'(if1.out_data),  32'(tv[i].ed));
      chk("tv_data0", 32'(if0.out_data),  32'(tv[i].ed));
      chk("tv_level", 32'(lvl1),          32'(tv[i].el));
      chk("tv_cnt",   32'(cnt1),          32'(tv[i].ec));
    end
    drain();

    send(8'hC0, 1'b0, 1'b0);
    chk("order_lsb_03", 32'(if0.out_data), 32'h03);
    chk("order_msb_c0", 32'(if1.out_data), 32'hC0);
    drain();

    for (int i = 0; i < 8; i++) begin
      step(1'b1, pat[i], 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("gap_cnt", 32'(cnt1), 32'((i + 1) % 8));
    end
    chk("gap_level", 32'(lvl1), 32'd1);
    chk("gap_data",  32'(if1.out_data), 32'hA5);
    drain();

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fs_cnt",   32'(cnt1), 32'd1);
    chk("fs_level", 32'(lvl1), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fs_level1", 32'(lvl1), 32'd1);
    chk("fs_msb",    32'(if1.out_data), 32'h80);
    chk("fs_lsb",    32'(if0.out_data), 32'h01);
    drain();

    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int k = 0; k < 5; k++) send(words[k], 1'b0, 1'b0);
    chk("ovr_level", 32'(lvl1), 32'd4);
    chk("ovr_set",   32'(ov1),  32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("ovr_order", 32'(if1.out_data), 32'(words[k]));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("ovr_empty",  32'(if1.out_valid), 32'd0);
    chk("ovr_sticky", 32'(ov1), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_clear", 32'(ov1), 32'd0);

    for (int k = 0; k < 4; k++) send(8'hA1 + 8'(k), 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b1);
    chk("fullpop_level", 32'(lvl1), 32'd4);
    chk("fullpop_ovr",   32'(ov1),  32'd0);
    chk("fullpop_head",  32'(if1.out_data), 32'hA2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_level", 32'(lvl1), 32'd0);
    chk("rst_cnt",   32'(cnt1), 32'd0);
    chk("rst_valid", 32'(if1.out_valid), 32'd0);
    chk("rst_data",  32'(if1.out_data), 32'd0);

    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 3) != 0,
           1'($urandom),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shiftreg_in_buf.md
SHIFTREG_IN_BUF -- requirements
Module: shiftreg_in_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning bits per word; legal range 2..32.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning words of output buffering; power of 2, minimum 2.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = first received bit lands in data[WIDTH-1] and 0 = first bit lands in data[0].
REQ-004 The block SHALL have port serclk  in  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port ser_in  in  1  serial data bit.
REQ-007 The block SHALL have port enable  in  1  active high; ser_in is sampled on this edge.
REQ-008 The block SHALL have port frame_start  in  1  abandons any partial word and restarts bit count.
REQ-009 The block SHALL have port out_data  out  WIDTH  word at buffer head.
REQ-010 The block SHALL have port out_valid  out  1  buffer non-empty.
REQ-011 The block SHALL have port out_ready  in  1  consumer accepts out_data when out_valid=1.
REQ-012 The block SHALL have port level  out  $clog2(DEPTH+1)  words held in buffer.
REQ-013 The block SHALL have port bit_cnt  out  $clog2(WIDTH)  bits of current partial word received.
REQ-014 The block SHALL have port overrun  out  1  sticky; a completed word was dropped.
REQ-015 The block SHALL have port clear_overrun  in  1  clears overrun.

Function
REQ-016 The block SHALL shift on every edge with enable=1 and hold the shift register and bit_cnt when enable=0; MSB_FIRST=1: {sr[WIDTH-2:0],ser_in}; MSB_FIRST=0: {ser_in,sr[WIDTH-1:1]}.
REQ-017 The block SHALL increment bit_cnt on each enabled edge and wrap bit_cnt to 0 on the edge receiving bit WIDTH-1.
REQ-018 On the edge receiving bit WIDTH-1, the block SHALL push the complete word, including that bit, into the buffer, so that out_valid rises the cycle after the last bit: latency 1 from last enable edge.
REQ-019 On frame_start=1, the block SHALL clear bit_cnt and the shift register and SHALL discard the partial word without pushing it.
REQ-020 With frame_start=1 and enable=1 together, the block SHALL take ser_in as bit 0 of the new word and set bit_cnt to 1.
REQ-021 The buffer SHALL pop the head when out_valid=1 and out_ready=1; out_ready with out_valid=0 SHALL have no effect.
REQ-022 Word order SHALL be FIFO and out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 On a push with level=DEPTH and no pop on the same edge, the block SHALL drop the word, keep buffer contents unchanged, and set overrun.
REQ-024 On a push with level=DEPTH and a pop on the same edge, both operations SHALL succeed, level SHALL stay at DEPTH, and overrun SHALL be unchanged.
REQ-025 On a simultaneous push and pop at any level, level SHALL be unchanged.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 clear_overrun=1 SHALL clear overrun; if an overrun event occurs on the same edge, set SHALL win.

Reset
REQ-028 With reset_n=0 at a rising edge, the block SHALL set the shift register, bit_cnt, level, pointers and overrun to 0, and out_valid to 0.
REQ-029 out_data SHALL be 0 after reset.
REQ-030 Reset mid-word or with a non-empty buffer SHALL discard all partial and buffered data.
REQ-031 Reset SHALL override enable, frame_start and out_ready.

Structure
REQ-032 A shared package SHALL hold the MSB_FIRST encoding constants and the $clog2-based width helpers; no typedefs are required.
REQ-033 The buffer SHALL be a sub-module shiftreg_in_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level); shift register, bit counter and overrun logic SHALL live in the top.

Verification
REQ-034 WIDTH=8, MSB_FIRST=1, enable held 1, bits 1,0,1,0,0,1,0,1 -> out_valid=1 the cycle after bit 8, out_data=8'hA5, level=1.
REQ-035 MSB_FIRST=0, same bits -> out_data=8'hA5 bit-reversed = 8'hA5 (palindrome); repeat with 1,1,0,0,0,0,0,0 -> out_data=8'h03.
REQ-036 Enable gapped (1 cycle on, 2 off) over 8 bits -> bit_cnt holds during gaps; single word, same value as contiguous case.
REQ-037 frame_start asserted after 5 bits, with enable=1 and ser_in=1, then 7 more bits -> no word from the partial; first word's bit 0 = 1; bit_cnt=1 after frame_start edge.
REQ-038 DEPTH=4, out_ready=0, 5 words sent -> level=4, overrun=1, words 1-4 read back in order; clear_overrun -> overrun=0.
REQ-039 Buffer full with a pop on the same edge as the last bit -> level stays 4, overrun=0; reset_n=0 mid-word -> level=0, bit_cnt=0, out_valid=0 next cycle.
